// File: rtl/write_dqs_fsm.sv
// Write-path DQS sequencer: orders preamble, data burst, interamble/postamble
// and drives the per-clock DQS bit pair, output enable and write_shift controls.
module write_dqs_fsm #(
  parameter int PRE_LEN   = 4,
  parameter int BURST_LEN = 8,
  parameter int POST_LEN  = 1,
  parameter int MAX_INTER = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_start,
  input  logic [2:0] i_wr_gap,
  input  logic [1:0] i_preamble_bits,
  input  logic [1:0] i_interamble_bits,
  output logic       o_wr_en,
  output logic       o_preamble_load,
  output logic       o_preamble_valid,
  output logic       o_interamble_valid,
  output logic [2:0] o_interamble_shift,
  output logic [1:0] o_dqs,
  output logic       o_dqs_oe,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_INTER = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [2:0]    gap_q, gap_d;
  logic          far_q, far_d;

  logic          last;
  logic          eff_pend;
  logic [2:0]    eff_gap;
  logic          gap_is_inter;
  logic [CW-1:0] wait_len;

  assign last     = (cnt_q == '0);
  // A request arriving on the final BURST cycle counts as already pending.
  assign eff_pend = pend_q | i_wr_start;
  assign eff_gap  = pend_q ? gap_q : i_wr_gap;
  assign gap_is_inter = (eff_gap != '0) && (int'(eff_gap) <= MAX_INTER);
  assign wait_len = CW'(gap_q) - CW'(POST_LEN + PRE_LEN);

  always_comb begin
    state_d         = state_q;
    cnt_d           = last ? cnt_q : cnt_q - 1'b1;
    pend_d          = pend_q;
    gap_d           = gap_q;
    far_d           = far_q;
    o_preamble_load = 1'b0;
    o_err           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wr_start) begin
          state_d         = S_PRE;
          cnt_d           = CW'(PRE_LEN - 1);
          o_preamble_load = 1'b1;
        end
      end
      S_PRE: begin
        o_err = i_wr_start;
        if (last) begin
          state_d = S_BURST;
          cnt_d   = CW'(BURST_LEN - 1);
        end
      end
      S_BURST: begin
        if (i_wr_start) begin
          if (pend_q) begin
            o_err = 1'b1;
          end else begin
            pend_d = 1'b1;
            gap_d  = i_wr_gap;
          end
        end
        if (last) begin
          pend_d = 1'b0;
          gap_d  = eff_gap;
          if (!eff_pend) begin
            state_d = S_POST;
            cnt_d   = CW'(POST_LEN - 1);
          end else if (eff_gap == '0) begin
            state_d = S_BURST;
            cnt_d   = CW'(BURST_LEN - 1);
          end else if (gap_is_inter) begin
            state_d = S_INTER;
            cnt_d   = CW'(eff_gap) - 1'b1;
          end else begin
            state_d = S_POST;
            cnt_d   = CW'(POST_LEN - 1);
            far_d   = 1'b1;
          end
        end
      end
      S_INTER: begin
        o_err = i_wr_start;
        if (last) begin
          state_d = S_BURST;
          cnt_d   = CW'(BURST_LEN - 1);
        end
      end
      S_POST: begin
        o_err = i_wr_start;
        if (last) begin
          if (!far_q) begin
            state_d = S_IDLE;
          end else if (wait_len == '0) begin
            state_d         = S_PRE;
            cnt_d           = CW'(PRE_LEN - 1);
            o_preamble_load = 1'b1;
            far_d           = 1'b0;
          end else begin
            state_d = S_GAP;
            cnt_d   = wait_len - 1'b1;
          end
        end
      end
      S_GAP: begin
        o_err = i_wr_start;
        if (last) begin
          state_d         = S_PRE;
          cnt_d           = CW'(PRE_LEN - 1);
          o_preamble_load = 1'b1;
          far_d           = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      far_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      far_q   <= far_d;
    end
  end

  assign o_wr_en            = (state_q == S_BURST);
  assign o_preamble_valid   = (state_q == S_PRE);
  assign o_interamble_valid = (state_q == S_INTER);
  assign o_busy             = (state_q != S_IDLE);
  assign o_dqs_oe           = (state_q == S_PRE) || (state_q == S_BURST) ||
                              (state_q == S_INTER) || (state_q == S_POST);

  always_comb begin
    o_interamble_shift = '0;
    if (state_q == S_INTER)
      o_interamble_shift = gap_q;
    else if ((state_q == S_BURST) && last && eff_pend && gap_is_inter)
      o_interamble_shift = eff_gap;
  end

  always_comb begin
    case (state_q)
      S_PRE:   o_dqs = i_preamble_bits;
      S_BURST: o_dqs = 2'b10;
      S_INTER: o_dqs = i_interamble_bits;
      default: o_dqs = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_write_dqs_fsm.sv
// Table-driven bench for write_dqs_fsm: per-cycle vectors with expected phase,
// expected outputs queued at drive time and compared mid-cycle.
module tb_write_dqs_fsm;

  typedef enum logic [2:0] {P_IDLE, P_PRE, P_BURST, P_INTER, P_POST, P_GAP} ph_t;

  typedef struct packed {
    logic       wr_en;
    logic       load;
    logic       pv;
    logic       iv;
    logic [2:0] sh;
    logic [1:0] dqs;
    logic       oe;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    logic       s;
    logic [2:0] g;
    logic [1:0] pb;
    logic [1:0] ib;
    ph_t        ph;
    logic       ld;
    logic       er;
    logic [2:0] sh;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_start = 1'b0;
  logic [2:0] wr_gap = '0;
  logic [1:0] pre_bits = '0;
  logic [1:0] inter_bits = '0;
  logic       wr_en, pre_load, pre_valid, inter_valid, dqs_oe, busy, err;
  logic [2:0] inter_shift;
  logic [1:0] dqs;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  out_t exp_q[$];

  write_dqs_fsm #(.PRE_LEN(4), .BURST_LEN(8), .POST_LEN(1), .MAX_INTER(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_start(wr_start), .i_wr_gap(wr_gap),
    .i_preamble_bits(pre_bits), .i_interamble_bits(inter_bits),
    .o_wr_en(wr_en), .o_preamble_load(pre_load), .o_preamble_valid(pre_valid),
    .o_interamble_valid(inter_valid), .o_interamble_shift(inter_shift),
    .o_dqs(dqs), .o_dqs_oe(dqs_oe), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic out_t got_out();
    return '{wr_en, pre_load, pre_valid, inter_valid, inter_shift, dqs, dqs_oe, busy, err};
  endfunction

  function automatic out_t expect_of(vec_t v);
    out_t o;
    o = '0;
    o.wr_en = (v.ph == P_BURST);
    o.pv    = (v.ph == P_PRE);
    o.iv    = (v.ph == P_INTER);
    o.oe    = (v.ph != P_IDLE) && (v.ph != P_GAP);
    o.busy  = (v.ph != P_IDLE);
    o.load  = v.ld;
    o.err   = v.er;
    o.sh    = v.sh;
    case (v.ph)
      P_PRE:   o.dqs = v.pb;
      P_BURST: o.dqs = 2'b10;
      P_INTER: o.dqs = v.ib;
      default: o.dqs = 2'b00;
    endcase
    return o;
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (wr_en,load,pv,iv,sh,dqs,oe,busy,err)", name, got, exp);
    end
  endtask

  task automatic add(logic s, logic [2:0] g, ph_t ph, logic ld, logic er,
                     logic [2:0] sh, logic [1:0] pb);
    vec_t v;
    v.s = s; v.g = g; v.ph = ph; v.ld = ld; v.er = er; v.sh = sh; v.pb = pb;
    v.ib = 2'($urandom_range(0, 3));
    vecs.push_back(v);
  endtask

  task automatic addn(ph_t ph, int n);
    for (int i = 0; i < n; i++) add(1'b0, 3'd0, ph, 1'b0, 1'b0, 3'd0, 2'($urandom_range(0, 3)));
  endtask

  // Eight BURST cycles; request at index k1 (accepted), optional second at k2 (rejected).
  task automatic burst(int k1, logic [2:0] g1, int k2, logic [2:0] g2, logic [2:0] sh_last);
    for (int i = 0; i < 8; i++) begin
      if (i == k1)      add(1'b1, g1, P_BURST, 1'b0, 1'b0, (i == 7) ? sh_last : 3'd0, 2'b00);
      else if (i == k2) add(1'b1, g2, P_BURST, 1'b0, 1'b1, (i == 7) ? sh_last : 3'd0, 2'b00);
      else              add(1'b0, 3'd0, P_BURST, 1'b0, 1'b0, (i == 7) ? sh_last : 3'd0, 2'b00);
    end
  endtask

  task automatic start_idle(logic [2:0] g);
    add(1'b1, g, P_IDLE, 1'b1, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic run(string name);
    vec_t v;
    out_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      wr_start   = v.s;
      wr_gap     = v.g;
      pre_bits   = v.pb;
      inter_bits = v.ib;
      exp_q.push_back(expect_of(v));
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i), got_out(), e);
    end
    vecs.delete();
    @(posedge clk);
    #1;
    wr_start = 1'b0;
    wr_gap   = '0;
  endtask

  initial begin
    #3;
    check("reset_outputs", got_out(), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single request; preamble pattern 10,01,10,10; gap ignored in IDLE.
    addn(P_IDLE, 2);
    start_idle(3'd5);
    add(1'b0, 3'd0, P_PRE, 1'b0, 1'b0, 3'd0, 2'b10);
    add(1'b0, 3'd0, P_PRE, 1'b0, 1'b0, 3'd0, 2'b01);
    add(1'b0, 3'd0, P_PRE, 1'b0, 1'b0, 3'd0, 2'b10);
    add(1'b0, 3'd0, P_PRE, 1'b0, 1'b0, 3'd0, 2'b10);
    addn(P_BURST, 8);
    addn(P_POST, 1);
    addn(P_IDLE, 2);
    run("single");

    // Interamble chain, gap 3, requested at burst cycle 4.
    start_idle(3'd0);
    addn(P_PRE, 4);
    burst(3, 3'd3, -1, 3'd0, 3'd3);
    for (int i = 0; i < 3; i++) add(1'b0, 3'd0, P_INTER, 1'b0, 1'b0, 3'd3, 2'b00);
    addn(P_BURST, 8);
    addn(P_POST, 1);
    addn(P_IDLE, 1);
    run("inter3");

    // Seamless chain on last burst cycle; also a rejected request in POSTAMBLE.
    start_idle(3'd0);
    addn(P_PRE, 4);
    burst(7, 3'd0, -1, 3'd0, 3'd0);
    addn(P_BURST, 8);
    add(1'b1, 3'd2, P_POST, 1'b0, 1'b1, 3'd0, 2'b00);
    addn(P_IDLE, 1);
    run("seamless");

    // Far chain, gap 7: postamble, gap wait, reloaded preamble; reject in GAP_WAIT.
    start_idle(3'd0);
    addn(P_PRE, 4);
    burst(2, 3'd7, -1, 3'd0, 3'd0);
    addn(P_POST, 1);
    add(1'b1, 3'd1, P_GAP, 1'b0, 1'b1, 3'd0, 2'b00);
    add(1'b0, 3'd0, P_GAP, 1'b1, 1'b0, 3'd0, 2'b00);
    addn(P_PRE, 4);
    addn(P_BURST, 8);
    addn(P_POST, 1);
    addn(P_IDLE, 1);
    run("far7");

    // Rejected in PREAMBLE, second request in same BURST rejected; first kept.
    start_idle(3'd0);
    add(1'b0, 3'd0, P_PRE, 1'b0, 1'b0, 3'd0, 2'($urandom_range(0, 3)));
    add(1'b1, 3'd0, P_PRE, 1'b0, 1'b1, 3'd0, 2'($urandom_range(0, 3)));
    addn(P_PRE, 2);
    burst(1, 3'd3, 5, 3'd0, 3'd3);
    for (int i = 0; i < 3; i++) add(1'b0, 3'd0, P_INTER, 1'b0, 1'b0, 3'd3, 2'b00);
    addn(P_BURST, 8);
    addn(P_POST, 1);
    addn(P_IDLE, 1);
    run("reject");

    // Async reset in the middle of an interamble.
    start_idle(3'd0);
    addn(P_PRE, 4);
    burst(0, 3'd2, -1, 3'd0, 3'd2);
    add(1'b0, 3'd0, P_INTER, 1'b0, 1'b0, 3'd2, 2'b00);
    run("pre_reset");
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", got_out(), '0);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", got_out(), '0);
    rst = 1'b1;

    addn(P_IDLE, 1);
    start_idle(3'd0);
    addn(P_PRE, 4);
    addn(P_BURST, 8);
    addn(P_POST, 1);
    addn(P_IDLE, 1);
    run("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule
